// File: rtl/stch2dec_pkg.sv
// Shared definitions for the stochastic-to-decimal converter.
//   ND_DEFAULT : default decimal precision, common with the decimal-to-stochastic
//                converters and the LFSR width of the stochastic network.
//   state_e    : converter FSM encoding (IDLE / COUNT).
package stch2dec_pkg;

    localparam int unsigned ND_DEFAULT = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_e;

endpackage

// File: rtl/stch_ones_counter.sv
// EN-qualified ones accumulator for a stochastic stream.
//   clk_i     : rising-edge clock
//   rst_ni    : synchronous reset, active-low
//   clr_i     : synchronous clear (takes priority over counting)
//   en_i      : count s_i on this cycle
//   s_i       : stochastic bit
//   sum_sat_o : accumulator + s_i, saturated to ND bits
module stch_ones_counter
    import stch2dec_pkg::*;
#(
    parameter int unsigned ND = ND_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic          s_i,
    output logic [ND-1:0] sum_sat_o
);

    // One extra bit so a full window of ones (2^ND) never wraps.
    logic [ND:0] acc_q;
    logic [ND:0] acc_d;
    logic [ND:0] sum;

    always_comb begin
        sum = acc_q + {{ND{1'b0}}, s_i};
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum;
        end
    end

    // Include the in-flight bit so the last sample lands in the published result.
    assign sum_sat_o = sum[ND] ? {ND{1'b1}} : sum[ND-1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/stch2dec.sv
// Stochastic-to-decimal converter: counts ones in S over 2^ND enabled samples
// and publishes the count on D with a one-cycle VALID strobe.
//   CLK   : rising-edge clock
//   INIT  : synchronous reset, active-low
//   START : begin a window when idle (ignored while busy)
//   EN    : sample qualifier
//   S     : stochastic bit
//   D     : result x/2^ND, held between completions
//   VALID : one-cycle strobe when D updates
//   BUSY  : high while a window is in progress
//
// state    | meaning
// ST_IDLE  | waiting for START, accumulator held at zero
// ST_COUNT | sampling S on EN=1 cycles until the window completes
module stch2dec
    import stch2dec_pkg::*;
#(
    parameter int unsigned ND   = ND_DEFAULT,
    parameter bit          CONT = 1'b0
) (
    input  logic          CLK,
    input  logic          INIT,
    input  logic          START,
    input  logic          EN,
    input  logic          S,
    output logic [ND-1:0] D,
    output logic          VALID,
    output logic          BUSY
);

    state_e        state_q, state_d;
    logic [ND-1:0] cnt_q, cnt_d;
    logic [ND-1:0] d_q, d_d;
    logic          valid_q, valid_d;
    logic          sample;
    logic          last;
    logic          acc_clr;
    logic [ND-1:0] sum_sat;

    assign sample  = (state_q == ST_COUNT) && EN;
    assign last    = sample && (cnt_q == {ND{1'b1}});
    // Clearing in IDLE and on the completing sample makes every window start
    // from zero, including back-to-back windows in continuous mode.
    assign acc_clr = (state_q == ST_IDLE) || last;

    stch_ones_counter #(
        .ND (ND)
    ) u_ones (
        .clk_i     (CLK),
        .rst_ni    (INIT),
        .clr_i     (acc_clr),
        .en_i      (sample),
        .s_i       (S),
        .sum_sat_o (sum_sat)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        valid_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (START) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (sample) begin
                    // Wraps to zero on the last sample, ready for the next window.
                    cnt_d = cnt_q + {{(ND-1){1'b0}}, 1'b1};
                end
                if (last) begin
                    d_d     = sum_sat;
                    valid_d = 1'b1;
                    if (!CONT) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!INIT) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            valid_q <= valid_d;
        end
    end

    assign D     = d_q;
    assign VALID = valid_q;
    assign BUSY  = (state_q == ST_COUNT);

endmodule

// File: tb/tb_stch2dec.sv
module tb_stch2dec;

    logic       clk = 1'b0;
    logic       init, start, en, s;
    logic [7:0] d;
    logic       valid, busy;
    logic       start_c, en_c, s_c;
    logic [7:0] d_c;
    logic       valid_c, busy_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stch2dec #(.ND(8), .CONT(1'b0)) dut (
        .CLK(clk), .INIT(init), .START(start), .EN(en), .S(s),
        .D(d), .VALID(valid), .BUSY(busy)
    );

    stch2dec #(.ND(8), .CONT(1'b1)) dut_c (
        .CLK(clk), .INIT(init), .START(start_c), .EN(en_c), .S(s_c),
        .D(d_c), .VALID(valid_c), .BUSY(busy_c)
    );

    // {en, s} for sample slot k (k=1 is the first edge after the START edge)
    function automatic logic [1:0] stim(input int mode, input int k);
        case (mode)
            0: return 2'b10;                                // all zeros
            1, 4: return {1'b1, (k % 4 == 1)};              // 64 ones in 256
            2: return 2'b11;                                // all ones
            3: return (k % 2 == 1) ? {1'b1, (k <= 19)} : 2'b01; // EN toggling
            default: return 2'b00;
        endcase
    endfunction

    // Runs one CONT=0 window; START edge is edge 0, VALID edges counted from it.
    task automatic run_window(input int mode, output int first_valid, output int n_valid,
                              output logic [7:0] d_at_valid, output logic busy_at_valid,
                              output logic busy_before, output logic [7:0] d_before,
                              output logic [7:0] d_end);
        logic [1:0] v;
        first_valid = -1; n_valid = 0;
        d_at_valid = 'x; busy_at_valid = 'x; busy_before = 'x; d_before = 'x;
        start = 1'b1; en = 1'b1; s = 1'b1;    // START cycle must not sample
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            v = stim(mode, k);
            en = v[1]; s = v[0];
            start = (mode == 4) && (k == 51 || k == 201);
            @(posedge clk); #1;
            if (valid) begin
                n_valid++;
                if (first_valid < 0) begin
                    first_valid = k; d_at_valid = d; busy_at_valid = busy;
                end
            end else if (first_valid < 0) begin
                busy_before = busy; d_before = d;
            end
        end
        en = 1'b0; s = 1'b0; start = 1'b0;
        d_end = d;
    endtask

    task automatic test_reset();
        init = 1'b0; start = 1'b0; en = 1'b0; s = 1'b0;
        start_c = 1'b0; en_c = 1'b0; s_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_d got %h exp 00", d); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        init = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_exact_count();
        int fv, nv; logic [7:0] dv, db, de; logic bv, bb;
        run_window(1, fv, nv, dv, bv, bb, db, de);
        checks++; if (fv !== 256) begin errors++; $display("FAIL exact_latency got %0d exp 256", fv); end
        checks++; if (nv !== 1) begin errors++; $display("FAIL exact_nvalid got %0d exp 1", nv); end
        checks++; if (dv !== 8'h40) begin errors++; $display("FAIL exact_d got %h exp 40", dv); end
        checks++; if (bv !== 1'b0) begin errors++; $display("FAIL exact_busy_at_valid got %b exp 0", bv); end
        checks++; if (bb !== 1'b1) begin errors++; $display("FAIL exact_busy_before got %b exp 1", bb); end
        checks++; if (db !== 8'h00) begin errors++; $display("FAIL exact_d_held got %h exp 00", db); end
        checks++; if (de !== 8'h40) begin errors++; $display("FAIL exact_d_stable got %h exp 40", de); end
    endtask

    task automatic test_saturation();
        int fv, nv; logic [7:0] dv, db, de; logic bv, bb;
        run_window(2, fv, nv, dv, bv, bb, db, de);
        checks++; if (fv !== 256) begin errors++; $display("FAIL sat_latency got %0d exp 256", fv); end
        checks++; if (dv !== 8'hFF) begin errors++; $display("FAIL sat_d got %h exp ff", dv); end
        checks++; if (db !== 8'h40) begin errors++; $display("FAIL sat_d_held got %h exp 40", db); end
    endtask

    task automatic test_en_gating();
        int fv, nv; logic [7:0] dv, db, de; logic bv, bb;
        run_window(3, fv, nv, dv, bv, bb, db, de);
        checks++; if (fv !== 511) begin errors++; $display("FAIL engate_latency got %0d exp 511", fv); end
        checks++; if (nv !== 1) begin errors++; $display("FAIL engate_nvalid got %0d exp 1", nv); end
        checks++; if (dv !== 8'h0A) begin errors++; $display("FAIL engate_d got %h exp 0a", dv); end
    endtask

    task automatic test_start_ignored();
        int fv, nv; logic [7:0] dv, db, de; logic bv, bb;
        run_window(4, fv, nv, dv, bv, bb, db, de);
        checks++; if (fv !== 256) begin errors++; $display("FAIL busystart_latency got %0d exp 256", fv); end
        checks++; if (nv !== 1) begin errors++; $display("FAIL busystart_nvalid got %0d exp 1", nv); end
        checks++; if (dv !== 8'h40) begin errors++; $display("FAIL busystart_d got %h exp 40", dv); end
    endtask

    task automatic test_reset_mid_window();
        int fv, nv; logic [7:0] dv, db, de; logic bv, bb;
        // previous result is 0x40; prime D to 0xFF so the clear is visible
        run_window(2, fv, nv, dv, bv, bb, db, de);
        start = 1'b1; en = 1'b0; s = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; en = 1'b1; s = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre got %b exp 1", busy); end
        init = 1'b0;
        @(posedge clk); #1;
        init = 1'b1; en = 1'b0; s = 1'b0;
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rstmid_d got %h exp 00", d); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        run_window(0, fv, nv, dv, bv, bb, db, de);
        checks++; if (nv !== 1) begin errors++; $display("FAIL rstmid_zero_nvalid got %0d exp 1", nv); end
        checks++; if (dv !== 8'h00) begin errors++; $display("FAIL rstmid_zero_d got %h exp 00", dv); end
        checks++; if (fv !== 256) begin errors++; $display("FAIL rstmid_zero_latency got %0d exp 256", fv); end
    endtask

    task automatic test_back_to_back();
        int k2 = -1;
        start = 1'b1; en = 1'b0; s = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; en = 1'b1; s = 1'b1;
        repeat (256) @(posedge clk);
        #1;
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1 got %b exp 1", valid); end
        start = 1'b1; s = 1'b1;      // restart immediately after completion
        @(posedge clk); #1;
        start = 1'b0; s = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", busy); end
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL b2b_d_held got %h exp ff", d); end
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (valid && k2 < 0) k2 = k;
        end
        en = 1'b0;
        checks++; if (k2 !== 256) begin errors++; $display("FAIL b2b_latency2 got %0d exp 256", k2); end
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL b2b_d2 got %h exp 00", d); end
    endtask

    task automatic test_cont();
        logic [7:0] lfsr = 8'h01;
        int exp_cnt [3] = '{0, 0, 0};
        int vedge [3];
        logic [7:0] vd [3];
        int nv = 0;
        int busy_low = 0;
        int diff;
        start_c = 1'b1; en_c = 1'b1; s_c = 1'b0;
        @(posedge clk); #1;
        start_c = 1'b0;
        for (int k = 1; k <= 800; k++) begin
            s_c = (lfsr < 8'hC0);
            if ((k - 1) / 256 < 3) exp_cnt[(k - 1) / 256] += int'(s_c);
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            @(posedge clk); #1;
            if (!busy_c) busy_low++;
            if (valid_c) begin
                if (nv < 3) begin vedge[nv] = k; vd[nv] = d_c; end
                nv++;
            end
        end
        en_c = 1'b0;
        checks++; if (nv !== 3) begin errors++; $display("FAIL cont_nvalid got %0d exp 3", nv); end
        checks++; if (busy_low !== 0) begin errors++; $display("FAIL cont_busy_low got %0d exp 0", busy_low); end
        if (nv >= 3) begin
            for (int w = 0; w < 3; w++) begin
                checks++;
                if (vedge[w] !== 256 * (w + 1)) begin
                    errors++; $display("FAIL cont_edge%0d got %0d exp %0d", w, vedge[w], 256 * (w + 1));
                end
                checks++;
                if (int'(vd[w]) !== exp_cnt[w]) begin
                    errors++; $display("FAIL cont_d%0d got %0d exp %0d", w, vd[w], exp_cnt[w]);
                end
                diff = int'(vd[w]) - 192;
                checks++;
                if (diff > 1 || diff < -1) begin
                    errors++; $display("FAIL cont_tol%0d got %h exp c0+-1", w, vd[w]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact_count();
        test_saturation();
        test_en_gating();
        test_start_ignored();
        test_reset_mid_window();
        test_back_to_back();
        test_cont();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
